// File: rtl/layers_stream.sv
// layers_stream: pools DEPTH_NB channels over a window of up_data beats, then adds bias,
// applies the activation and rescales each result to IMG_WIDTH, queueing results in an
// output FIFO so that a stalled consumer does not stall accumulation.
//  clk, rst                : clock, synchronous active-high reset
//  cfg_data/addr/valid     : config write port (shift, pool_nb, bypass, leaky, leak, mode)
//  bias_bus                : per-channel bias, taken on the window-closing beat
//  up_data/valid/rdy       : per-channel accumulated sums in
//  dn_data/valid/rdy       : FIFO head out
//  fifo_count              : occupied FIFO entries
module layers_stream #(
    parameter int CFG_DWIDTH = 32,
    parameter int CFG_AWIDTH = 5,
    parameter int CFG_ADDR   = 2,
    parameter int DEPTH_NB   = 16,
    parameter int IMG_WIDTH  = 16,
    parameter int KER_WIDTH  = 16,
    parameter int NUM_WIDTH  = 33,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [CFG_DWIDTH-1:0]           cfg_data,
    input  logic [CFG_AWIDTH-1:0]           cfg_addr,
    input  logic                            cfg_valid,
    input  logic [DEPTH_NB*KER_WIDTH-1:0]   bias_bus,
    input  logic [DEPTH_NB*NUM_WIDTH-1:0]   up_data,
    input  logic                            up_valid,
    output logic                            up_rdy,
    output logic [DEPTH_NB*IMG_WIDTH-1:0]   dn_data,
    output logic                            dn_valid,
    input  logic                            dn_rdy,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(NUM_WIDTH);
    localparam int NB = DEPTH_NB * NUM_WIDTH;
    localparam int IB = DEPTH_NB * IMG_WIDTH;
    localparam logic signed [NUM_WIDTH-1:0] NMAX = {1'b0, {(NUM_WIDTH-1){1'b1}}};
    localparam logic signed [NUM_WIDTH-1:0] NMIN = {1'b1, {(NUM_WIDTH-1){1'b0}}};
    localparam logic signed [NUM_WIDTH:0] IMAX = {{(NUM_WIDTH-IMG_WIDTH+2){1'b0}}, {(IMG_WIDTH-1){1'b1}}};
    localparam logic signed [NUM_WIDTH:0] IMIN = ~IMAX;

    function automatic logic signed [NUM_WIDTH-1:0] sat_add(input logic signed [NUM_WIDTH-1:0] a, input logic signed [NUM_WIDTH-1:0] b);
        logic [NUM_WIDTH:0] s;
        s = {a[NUM_WIDTH-1], a} + {b[NUM_WIDTH-1], b};
        return (s[NUM_WIDTH] != s[NUM_WIDTH-1]) ? (s[NUM_WIDTH] ? NMIN : NMAX) : s[NUM_WIDTH-1:0];
    endfunction

    // One guard bit above NUM_WIDTH holds x plus the rounding constant without overflow.
    function automatic logic [IMG_WIDTH-1:0] rescale(input logic signed [NUM_WIDTH-1:0] x, input logic [SW-1:0] s);
        logic [NUM_WIDTH:0] rnd;
        logic signed [NUM_WIDTH:0] t;
        rnd = (s != '0) ? (NUM_WIDTH+1)'(1) << (s - 1'b1) : '0;
        t = {x[NUM_WIDTH-1], x} + rnd;
        t = t >>> s;
        return (t > IMAX) ? IMAX[IMG_WIDTH-1:0] : (t < IMIN) ? IMIN[IMG_WIDTH-1:0] : t[IMG_WIDTH-1:0];
    endfunction

    logic [21:0] cfg, shd;
    logic pend;
    logic [7:0] cnt;
    logic [3:0] v;
    logic [NB-1:0] acc, s1, s2, s3, pool_nx, bias_nx, act_nx;
    logic [DEPTH_NB*KER_WIDTH-1:0] b1;
    logic [IB-1:0] s4, res_nx;
    logic [IB-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [CW:0] occ;
    logic [SW-1:0] sh;
    logic cfg_hit, idle, beat, closing, push, pop;
    logic unused_cfg;

    assign unused_cfg = ^cfg_data[CFG_DWIDTH-1:22];
    assign sh = (cfg[7:0] > 8'(NUM_WIDTH-1)) ? SW'(NUM_WIDTH-1) : cfg[SW-1:0];
    // Credit covers queued entries plus every window still travelling through the pipeline.
    assign occ = (CW+1)'(fifo_count) + (CW+1)'(v[0]) + (CW+1)'(v[1]) + (CW+1)'(v[2]) + (CW+1)'(v[3]);
    // A pending config only blocks the start of a new window, so an open one can still close.
    assign up_rdy = !rst && !(pend && cnt == 8'd0) && occ < (CW+1)'(FIFO_DEPTH);
    assign cfg_hit = cfg_valid && cfg_addr == CFG_AWIDTH'(CFG_ADDR);
    assign idle = cnt == 8'd0 && v == 4'd0;
    assign beat = up_valid && up_rdy;
    assign closing = beat && cnt == cfg[15:8];
    assign push = v[3];
    assign pop = dn_valid && dn_rdy;
    assign dn_valid = fifo_count != '0;
    assign dn_data = dn_valid ? mem[rp] : '0;

    for (genvar c = 0; c < DEPTH_NB; c++) begin : g_ch
        logic signed [NUM_WIDTH-1:0] u, a, p, q, r, bx, lk;
        assign u = up_data[c*NUM_WIDTH +: NUM_WIDTH];
        assign a = acc[c*NUM_WIDTH +: NUM_WIDTH];
        assign p = s1[c*NUM_WIDTH +: NUM_WIDTH];
        assign q = s2[c*NUM_WIDTH +: NUM_WIDTH];
        assign r = s3[c*NUM_WIDTH +: NUM_WIDTH];
        assign bx = NUM_WIDTH'($signed(b1[c*KER_WIDTH +: KER_WIDTH]));
        assign lk = q >>> cfg[20:18];
        assign pool_nx[c*NUM_WIDTH +: NUM_WIDTH] = (cnt == 8'd0) ? u : cfg[21] ? sat_add(a, u) : ((a > u) ? a : u);
        assign bias_nx[c*NUM_WIDTH +: NUM_WIDTH] = sat_add(p, bx);
        assign act_nx[c*NUM_WIDTH +: NUM_WIDTH] = (cfg[16] || !q[NUM_WIDTH-1]) ? q : cfg[17] ? lk : '0;
        assign res_nx[c*IMG_WIDTH +: IMG_WIDTH] = rescale(r, sh);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg <= '0;
            shd <= '0;
            pend <= 1'b0;
            cnt <= '0;
            v <= '0;
            wp <= '0;
            rp <= '0;
            fifo_count <= '0;
        end else begin
            if (beat) cnt <= closing ? 8'd0 : cnt + 8'd1;
            v <= {v[2:0], closing};
            if (cfg_hit) begin
                shd <= cfg_data[21:0];
                pend <= 1'b1;
            end else if (pend && idle) begin
                cfg <= shd;
                pend <= 1'b0;
            end
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (beat) acc <= pool_nx;
        if (closing) begin
            s1 <= pool_nx;
            b1 <= bias_bus;
        end
        s2 <= bias_nx;
        s3 <= act_nx;
        s4 <= res_nx;
        if (push) mem[wp] <= s4;
    end
endmodule

// File: tb/tb_layers_stream.sv
// tb_layers_stream: directed and randomized checks of layers_stream against a behavioural model.
module tb_layers_stream;
    localparam int D = 16, NW = 33, IW = 16, KW = 16, FD = 4;

    logic clk = 0, rst = 1;
    logic [31:0] cfg_data = '0;
    logic [4:0] cfg_addr = '0;
    logic cfg_valid = 0;
    logic [D*KW-1:0] bias_bus = '0;
    logic [D*NW-1:0] up_data = '0;
    logic up_valid = 0, up_rdy;
    logic [D*IW-1:0] dn_data;
    logic dn_valid, dn_rdy = 0;
    logic [2:0] fifo_count;

    int total = 0, bad = 0, npop = 0, n0 = 0;
    bit rnd = 0;
    logic [D*IW-1:0] q[$];
    logic [D*IW-1:0] e;
    logic [21:0] m_cfg = '0, m_shd = '0;
    bit m_pend = 0;
    int wk = 0;
    longint wacc[D], bv[D], bb[D];

    always #5 clk = ~clk;

    layers_stream #(.CFG_DWIDTH(32), .CFG_AWIDTH(5), .CFG_ADDR(2), .DEPTH_NB(D), .IMG_WIDTH(IW),
                    .KER_WIDTH(KW), .NUM_WIDTH(NW), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .cfg_data(cfg_data), .cfg_addr(cfg_addr), .cfg_valid(cfg_valid),
        .bias_bus(bias_bus), .up_data(up_data), .up_valid(up_valid), .up_rdy(up_rdy),
        .dn_data(dn_data), .dn_valid(dn_valid), .dn_rdy(dn_rdy), .fifo_count(fifo_count));

    function automatic longint sat(input longint x, input int w);
        longint hi, lo;
        hi = (64'sd1 <<< (w - 1)) - 1;
        lo = -hi - 1;
        return x > hi ? hi : (x < lo ? lo : x);
    endfunction

    function automatic longint post(input longint p, input longint b, input logic [21:0] c);
        longint x;
        int sh;
        x = sat(p + b, NW);
        if (!c[16] && x < 0) x = c[17] ? (x >>> c[20:18]) : 64'sd0;
        sh = (c[7:0] > NW - 1) ? NW - 1 : int'(c[7:0]);
        if (sh > 0) x = x + (64'sd1 <<< (sh - 1));
        return sat(x >>> sh, IW);
    endfunction

    function automatic longint dch(input int c);
        logic [IW-1:0] s;
        s = dn_data[c*IW +: IW];
        return longint'($signed(s));
    endfunction

    function automatic longint rnd_num();
        longint r;
        r = longint'($signed($urandom));
        case ($urandom_range(0, 3))
            0: r = r >>> $urandom_range(16, 28);
            1: r = r * 2;
            2: r = r >>> 8;
            default: r = longint'($urandom_range(0, 100)) - 50;
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_beat();
        longint y;
        if (wk == 0 && m_pend) begin
            m_cfg = m_shd;
            m_pend = 0;
        end
        for (int c = 0; c < D; c++)
            wacc[c] = (wk == 0) ? bv[c] : m_cfg[21] ? sat(wacc[c] + bv[c], NW) : (bv[c] > wacc[c] ? bv[c] : wacc[c]);
        if (wk == int'(m_cfg[15:8])) begin
            for (int c = 0; c < D; c++) begin
                y = post(wacc[c], bb[c], m_cfg);
                e[c*IW +: IW] = y[IW-1:0];
            end
            q.push_back(e);
            wk = 0;
        end else wk++;
    endtask

    task automatic send();
        bit ok = 0;
        for (int c = 0; c < D; c++) begin
            up_data[c*NW +: NW] = bv[c][NW-1:0];
            bias_bus[c*KW +: KW] = bb[c][KW-1:0];
        end
        if (rnd) dn_rdy = 1'($urandom_range(0, 1));
        up_valid = 1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (up_rdy) begin
                ok = 1;
                break;
            end
            @(posedge clk);
            #1 if (rnd) dn_rdy = 1'($urandom_range(0, 1));
        end
        chk("accept", longint'(ok), 1);
        @(posedge clk);
        if (ok) model_beat();
        #1 up_valid = 0;
    endtask

    task automatic cfg_write(input logic [4:0] a, input logic [21:0] w);
        cfg_addr = a;
        cfg_data = {10'h3a5, w};
        cfg_valid = 1;
        @(posedge clk);
        #1 cfg_valid = 0;
        if (a == 5'd2) begin
            m_shd = w;
            m_pend = 1;
        end
    endtask

    task automatic clear_beat();
        for (int c = 0; c < D; c++) begin
            bv[c] = 0;
            bb[c] = 0;
        end
    endtask

    task automatic fill_rand();
        for (int c = 0; c < D; c++) begin
            bv[c] = rnd_num();
            bb[c] = longint'($signed(16'($urandom)));
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic resync();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        dn_rdy = 1;
        for (int i = 0; i < 300 && q.size() > 0; i++) @(negedge clk);
        chk("drain_left", longint'(q.size()), 0);
        resync();
        chk("fifo_empty", longint'(fifo_count), 0);
    endtask

    task automatic do_reset();
        rst = 1;
        up_valid = 0;
        cfg_valid = 0;
        q.delete();
        wk = 0;
        m_cfg = '0;
        m_shd = '0;
        m_pend = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_up_rdy", longint'(up_rdy), 0);
        chk("rst_dn_valid", longint'(dn_valid), 0);
        chk("rst_fifo_count", longint'(fifo_count), 0);
        total++;
        assert (dn_data === '0) else begin
            bad++;
            $error("FAIL rst_dn_data observed=%h expected=0", dn_data);
        end
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rdy_after_rst", longint'(up_rdy), 1);
        resync();
    endtask

    always @(negedge clk) begin
        if (!rst && dn_valid && dn_rdy) begin
            total++;
            npop++;
            if (q.size() == 0) begin
                bad++;
                $error("FAIL sb_extra observed=%h expected=none", dn_data);
            end else begin
                logic [D*IW-1:0] x;
                x = q.pop_front();
                assert (dn_data === x) else begin
                    bad++;
                    $error("FAIL sb_data observed=%h expected=%h", dn_data, x);
                end
            end
        end
    end

    initial begin
        do_reset();
        // single-beat window, exact latency
        dn_rdy = 1;
        clear_beat();
        bv[0] = 5;
        bv[1] = -3;
        send();
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i < 5) chk("lat_early", longint'(dn_valid), 0);
        end
        chk("lat_valid", longint'(dn_valid), 1);
        chk("t1_ch0", dch(0), 5);
        chk("t1_ch1", dch(1), 0);
        resync();
        drain();
        // three-beat max window
        cfg_write(2, 22'(2 << 8));
        dn_rdy = 0;
        clear_beat();
        bv[0] = 7;
        send();
        bv[0] = -2;
        send();
        bv[0] = 9;
        send();
        settle(6);
        chk("max_one_entry", longint'(fifo_count), 1);
        chk("max_ch0", dch(0), 9);
        resync();
        drain();
        // sum with bias and rounding shift
        cfg_write(2, 22'((1 << 21) | (1 << 8) | 2));
        dn_rdy = 0;
        clear_beat();
        bb[0] = 1;
        bv[0] = 6;
        send();
        bv[0] = 3;
        send();
        settle(6);
        chk("sum_round", dch(0), 3);
        resync();
        drain();
        // leaky relu and output saturation
        cfg_write(2, 22'((1 << 17) | (1 << 18)));
        dn_rdy = 0;
        clear_beat();
        bv[0] = -8;
        bv[1] = 64'sd1 <<< 20;
        bv[2] = -(64'sd1 <<< 20);
        send();
        settle(6);
        chk("leaky", dch(0), -4);
        chk("sat_hi", dch(1), 32767);
        chk("sat_lo", dch(2), -32768);
        resync();
        drain();
        // credit stall with a blocked consumer, then in-order release
        cfg_write(2, 22'd0);
        dn_rdy = 0;
        n0 = npop;
        for (int i = 0; i < 4; i++) begin
            fill_rand();
            send();
        end
        @(negedge clk);
        chk("credit_block", longint'(up_rdy), 0);
        settle(6);
        chk("full_count", longint'(fifo_count), 4);
        total++;
        assert (dn_data === q[0]) else begin
            bad++;
            $error("FAIL full_head observed=%h expected=%h", dn_data, q[0]);
        end
        resync();
        dn_rdy = 1;
        for (int i = 0; i < 4; i++) begin
            fill_rand();
            send();
        end
        drain();
        chk("delivered", longint'(npop - n0), 8);
        // config written inside an open window
        cfg_write(2, 22'(2 << 8));
        fill_rand();
        send();
        cfg_write(2, 22'((1 << 21) | 1));
        fill_rand();
        send();
        fill_rand();
        send();
        @(negedge clk);
        chk("pend_block", longint'(up_rdy), 0);
        resync();
        fill_rand();
        send();
        drain();
        // reset in the middle of an open window
        cfg_write(2, 22'((1 << 21) | (1 << 8)));
        fill_rand();
        send();
        do_reset();
        dn_rdy = 0;
        clear_beat();
        bv[0] = 123;
        send();
        settle(6);
        chk("post_rst", dch(0), 123);
        resync();
        drain();
        // writes to another address are ignored
        cfg_write(3, 22'(5 << 8));
        dn_rdy = 0;
        fill_rand();
        send();
        settle(6);
        chk("ign_addr", longint'(dn_valid), 1);
        resync();
        drain();
        // randomized configs and data with a random consumer
        for (int it = 0; it < 8; it++) begin
            logic [21:0] w;
            w[7:0] = (it == 3) ? 8'd255 : 8'($urandom_range(0, 40));
            w[15:8] = 8'($urandom_range(0, 3));
            w[21:16] = 6'($urandom);
            cfg_write(2, w);
            rnd = 1;
            for (int n = 0; n < 3 * (int'(w[15:8]) + 1); n++) begin
                fill_rand();
                send();
            end
            rnd = 0;
            drain();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
